// File: rtl/pb_sched_pkg.sv
// Shared state encoding, default parameters and width helpers for the push-button scheduler.
package pb_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_LOCKOUT = 2'd2
  } sched_state_t;

  localparam int DEF_N_BTN         = 4;
  localparam int DEF_TICK_DIV      = 10;
  localparam int DEF_LOCKOUT_TICKS = 8;
  localparam int DEF_REPEAT_TICKS  = 50;

  function automatic int calc_idw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int calc_cw(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pb_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping modulo N.
module pb_rr_pick
  import pb_sched_pkg::*;
#(
  parameter int N = DEF_N_BTN,
  localparam int IW = calc_idw(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[(int'(ptr) + k) % N]) begin
        found = 1'b1;
        idx   = IW'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/pb_cmd_scheduler.sv
// Turns debounced button rises into one-at-a-time round-robin commands with a post-accept lockout.
// Define HOLD_REPEAT_EN to add per-button auto-repeat requests while a button is held.
module pb_cmd_scheduler
  import pb_sched_pkg::*;
#(
  parameter int N_BTN         = DEF_N_BTN,
  parameter int TICK_DIV      = DEF_TICK_DIV,
  parameter int LOCKOUT_TICKS = DEF_LOCKOUT_TICKS,
  parameter int REPEAT_TICKS  = DEF_REPEAT_TICKS,
  localparam int IDW = calc_idw(N_BTN)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_BTN-1:0] i_pb_level,
  output logic             o_sample_en,
  output logic             o_cmd_valid,
  output logic [IDW-1:0]   o_cmd_id,
  input  logic             i_cmd_ready,
  output logic [N_BTN-1:0] o_pending,
  output logic             o_busy,
  output logic             o_overflow
);

  localparam int TW = calc_cw(TICK_DIV - 1);
  localparam int LW = calc_cw(LOCKOUT_TICKS);

  if (TICK_DIV < 2) begin : g_bad_tick_div
    $error("TICK_DIV must be at least 2");
  end
  if (REPEAT_TICKS < 1) begin : g_bad_repeat
    $error("REPEAT_TICKS must be at least 1");
  end

  logic [TW-1:0]    tick_q;
  logic             sample_q;
  logic [N_BTN-1:0] level_q;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] req_set;
  logic [N_BTN-1:0] pend_q, pend_d;
  logic             ovf_q, ovf_d;

  sched_state_t     state_q, state_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic [IDW-1:0]   cmd_id_q, cmd_id_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [LW-1:0]    lock_q, lock_d;
  logic [N_BTN-1:0] grant_clr;
  logic             pick_found;
  logic [IDW-1:0]   pick_idx;

  // Strobe is registered so it lands the cycle after the counter's terminal value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tick_q   <= '0;
      sample_q <= 1'b0;
    end else begin
      sample_q <= (tick_q == TW'(TICK_DIV - 1));
      tick_q   <= (tick_q == TW'(TICK_DIV - 1)) ? '0 : tick_q + TW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      level_q <= '0;
    end else begin
      level_q <= i_pb_level;
    end
  end

  assign rise = i_pb_level & ~level_q;

`ifdef HOLD_REPEAT_EN
  localparam int RW = calc_cw(REPEAT_TICKS - 1);

  logic [N_BTN-1:0][RW-1:0] rep_cnt_q;
  logic [N_BTN-1:0]         repeat_req;

  always_comb begin
    repeat_req = '0;
    for (int i = 0; i < N_BTN; i++) begin
      repeat_req[i] = i_pb_level[i] & ~rise[i] & sample_q &
                      (rep_cnt_q[i] == RW'(REPEAT_TICKS - 1));
    end
  end

  // Counter restarts on a fresh press or whenever the button is released.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rep_cnt_q <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (!i_pb_level[i] || rise[i]) begin
          rep_cnt_q[i] <= '0;
        end else if (sample_q) begin
          rep_cnt_q[i] <= repeat_req[i] ? '0 : rep_cnt_q[i] + RW'(1);
        end
      end
    end
  end

  assign req_set = rise | repeat_req;
`else
  assign req_set = rise;
`endif

  pb_rr_pick #(.N(N_BTN)) u_pick (
    .req   (pend_q),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    cmd_valid_d = cmd_valid_q;
    cmd_id_d    = cmd_id_q;
    ptr_d       = ptr_q;
    lock_d      = lock_q;
    grant_clr   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          cmd_id_d            = pick_idx;
          cmd_valid_d         = 1'b1;
          grant_clr[pick_idx] = 1'b1;
          state_d             = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (i_cmd_ready) begin
          cmd_valid_d = 1'b0;
          ptr_d       = (cmd_id_q == IDW'(N_BTN - 1)) ? '0 : cmd_id_q + IDW'(1);
          lock_d      = LW'(LOCKOUT_TICKS);
          state_d     = (LOCKOUT_TICKS == 0) ? ST_IDLE : ST_LOCKOUT;
        end
      end
      ST_LOCKOUT: begin
        if (sample_q) begin
          if (lock_q <= LW'(1)) begin
            lock_d  = '0;
            state_d = ST_IDLE;
          end else begin
            lock_d = lock_q - LW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A rise coinciding with its own grant is a new request, not an overflow.
  always_comb begin
    pend_d = (pend_q & ~grant_clr) | req_set;
    ovf_d  = ovf_q | (|(req_set & pend_q & ~grant_clr));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      cmd_valid_q <= 1'b0;
      cmd_id_q    <= '0;
      ptr_q       <= '0;
      lock_q      <= '0;
      pend_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_id_q    <= cmd_id_d;
      ptr_q       <= ptr_d;
      lock_q      <= lock_d;
      pend_q      <= pend_d;
      ovf_q       <= ovf_d;
    end
  end

  assign o_sample_en = sample_q;
  assign o_cmd_valid = cmd_valid_q;
  assign o_cmd_id    = cmd_id_q;
  assign o_pending   = pend_q;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_overflow  = ovf_q;

endmodule

// File: tb/tb_pb_cmd_scheduler.sv
// Bench for pb_cmd_scheduler: directed scenarios with literal expectations plus random traffic against a queue-level model.
module tb_pb_cmd_scheduler;

  localparam int N  = 4;
  localparam int TD = 10;
  localparam int LK = 8;
  localparam int RP = 3;
  localparam int IW = 2;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic [N-1:0]  lvl   = '0;
  logic          rdy   = 1'b0;
  logic          sample_en;
  logic          cmd_valid;
  logic [IW-1:0] cmd_id;
  logic [N-1:0]  pending;
  logic          busy;
  logic          overflow;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;
  int acc_q[$];

  pb_cmd_scheduler #(
    .N_BTN         (N),
    .TICK_DIV      (TD),
    .LOCKOUT_TICKS (LK),
    .REPEAT_TICKS  (RP)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_pb_level  (lvl),
    .o_sample_en (sample_en),
    .o_cmd_valid (cmd_valid),
    .o_cmd_id    (cmd_id),
    .i_cmd_ready (rdy),
    .o_pending   (pending),
    .o_busy      (busy),
    .o_overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int acc_at(input int k);
    return (k < acc_q.size()) ? acc_q[k] : -1;
  endfunction

  // Reference model: pending set, one offered command, remaining lockout ticks.
  int           m_cnt, m_id, m_ptr, m_left, j;
  bit           m_se, m_ovf, m_offer;
  logic [N-1:0] m_lvlq, m_pend, m_rise, m_set, m_clr;
`ifdef HOLD_REPEAT_EN
  int           m_rc [N];
`endif

  always begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_cnt = 0; m_se = 1'b0; m_lvlq = '0; m_pend = '0; m_ovf = 1'b0;
      m_offer = 1'b0; m_id = 0; m_ptr = 0; m_left = 0;
`ifdef HOLD_REPEAT_EN
      for (int i = 0; i < N; i++) m_rc[i] = 0;
`endif
    end else begin
      m_rise = lvl & ~m_lvlq;
      m_set  = m_rise;
      m_clr  = '0;
`ifdef HOLD_REPEAT_EN
      for (int i = 0; i < N; i++) begin
        if (!lvl[i] || m_rise[i]) m_rc[i] = 0;
        else if (m_se) begin
          m_rc[i]++;
          if (m_rc[i] == RP) begin m_set[i] = 1'b1; m_rc[i] = 0; end
        end
      end
`endif
      if (!(m_offer || m_left > 0)) begin
        for (int k = 0; k < N; k++) begin
          j = (m_ptr + k) % N;
          if (!m_offer && m_pend[j]) begin
            m_offer = 1'b1; m_id = j; m_clr[j] = 1'b1;
          end
        end
      end else if (m_offer) begin
        if (rdy) begin m_offer = 1'b0; m_ptr = (m_id + 1) % N; m_left = LK; end
      end else if (m_se) begin
        m_left--;
      end
      if ((m_set & m_pend & ~m_clr) != '0) m_ovf = 1'b1;
      m_pend = (m_pend & ~m_clr) | m_set;
      m_lvlq = lvl;
      m_se   = (m_cnt == TD - 1);
      m_cnt  = (m_cnt + 1) % TD;
    end
  end

  always begin
    @(negedge clk);
    if (rst_n && cmp_en) begin
      check("sample_en", int'(sample_en), int'(m_se));
      check("cmd_valid", int'(cmd_valid), int'(m_offer));
      check("cmd_id",    int'(cmd_id),    m_id);
      check("pending",   int'(pending),   int'(m_pend));
      check("busy",      int'(busy),      int'(m_offer || m_left > 0));
      check("overflow",  int'(overflow),  int'(m_ovf));
    end
  end

  always begin
    @(posedge clk);
    if (rst_n && cmd_valid && rdy) acc_q.push_back(int'(cmd_id));
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; lvl = '0; rdy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    acc_q.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    int ticks;
    bit done;
    cmp_en = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Strobe cadence from reset release, nothing else moving.
    for (int c = 1; c <= 35; c++) begin
      @(negedge clk);
      check("tick_cadence", int'(sample_en), int'(c % TD == 0));
      check("idle_valid", int'(cmd_valid), 0);
    end

    // Single press of button 2, downstream always ready.
    lvl[2] = 1'b1; rdy = 1'b1;
    @(negedge clk);
    check("s2_pending", int'(pending), 4);
    @(negedge clk);
    check("s2_valid", int'(cmd_valid), 1);
    check("s2_id", int'(cmd_id), 2);
    lvl[2] = 1'b0;
    ticks = 0; done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
      else if (sample_en && !cmd_valid) ticks++;
    end
    check("s2_idle_reached", int'(done), 1);
    check("s2_lock_ticks", ticks, LK);
    check("s2_acc_count", acc_q.size(), 1);
    check("s2_acc_id", acc_at(0), 2);

    // Three simultaneous presses, downstream stalled for five cycles.
    do_reset();
    lvl = 4'b1011; rdy = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 10 && !done; c++) begin
      @(negedge clk);
      if (cmd_valid) done = 1'b1;
    end
    check("s3_valid_seen", int'(done), 1);
    lvl = '0;
    for (int c = 0; c < 5; c++) begin
      check("s3_hold_valid", int'(cmd_valid), 1);
      check("s3_hold_id", int'(cmd_id), 0);
      if (c < 4) @(negedge clk);
    end
    rdy = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 1000 && !done; c++) begin
      @(negedge clk);
      if (acc_q.size() >= 3 && !busy) done = 1'b1;
    end
    check("s3_drained", int'(done), 1);
    check("s3_acc_count", acc_q.size(), 3);
    check("s3_order0", acc_at(0), 0);
    check("s3_order1", acc_at(1), 1);
    check("s3_order2", acc_at(2), 3);

    // Re-press of button 1 while it is still pending during lockout.
    check("s4_ovf_clear", int'(overflow), 0);
    acc_q.delete();
    @(negedge clk);
    lvl[0] = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (busy && !cmd_valid) done = 1'b1;
    end
    check("s4_in_lockout", int'(done), 1);
    lvl[0] = 1'b0;
    lvl[1] = 1'b1;
    @(negedge clk);
    lvl[1] = 1'b0;
    @(negedge clk);
    lvl[1] = 1'b1;
    @(negedge clk);
    lvl[1] = 1'b0;
    check("s4_overflow", int'(overflow), 1);
    check("s4_pending", int'(pending), 2);
    done = 1'b0;
    for (int c = 0; c < 500 && !done; c++) begin
      @(negedge clk);
      if (acc_q.size() >= 2 && !busy) done = 1'b1;
    end
    check("s4_drained", int'(done), 1);
    check("s4_acc_count", acc_q.size(), 2);
    check("s4_acc0", acc_at(0), 0);
    check("s4_acc1", acc_at(1), 1);
    check("s4_ovf_sticky", int'(overflow), 1);

    // Long hold of button 0.
    do_reset();
    lvl[0] = 1'b1; rdy = 1'b1;
    repeat (200) @(negedge clk);
`ifndef HOLD_REPEAT_EN
    check("hold_single_cmd", acc_q.size(), 1);
`endif
    lvl = '0;
    repeat (100) @(negedge clk);

    // Asynchronous reset while a command is offered.
    rdy = 1'b0;
    lvl = 4'b1100;
    done = 1'b0;
    for (int c = 0; c < 10 && !done; c++) begin
      @(negedge clk);
      if (cmd_valid) done = 1'b1;
    end
    check("s5_valid_seen", int'(done), 1);
    @(negedge clk);
    check("s5_pend_before", int'(pending != '0), 1);
    #2 rst_n = 1'b0;
    #1;
    check("s5_rst_valid", int'(cmd_valid), 0);
    check("s5_rst_pending", int'(pending), 0);
    check("s5_rst_busy", int'(busy), 0);
    check("s5_rst_sample", int'(sample_en), 0);
    @(negedge clk);
    lvl = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) begin
        int b;
        b = int'($urandom_range(0, N - 1));
        lvl[b] = ~lvl[b];
      end
      rdy = ($urandom_range(0, 2) != 0);
    end

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pb_cmd_scheduler.md
Name: pb_cmd_scheduler

Overview:
- Sequences front-panel push buttons into single commands for the camera control logic.
- Generates the shared sample-enable strobe used by the per-button debouncers. Detects rising edges on their debounced levels and queues one pending request per button.
- Grants pending requests round-robin, one at a time, over a valid/ready handshake. Enforces a lockout period after each accepted command.
- Sits between the debounce instances and the register-config / capture sequencer.

Parameters:
- N_BTN, 4, number of buttons / requesters (2..16).
- TICK_DIV, 10, o_sample_en period in i_clk cycles (>=2).
- LOCKOUT_TICKS, 8, sample ticks to wait after an accepted command (0 = no lockout).
- REPEAT_TICKS, 50, sample ticks of continuous hold before an auto-repeat request (used only with HOLD_REPEAT_EN; >=1).
- IDW, derived localparam, $clog2(N_BTN), command id width.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_pb_level  in  N_BTN  debounced button levels, synchronous to i_clk
- o_sample_en  out  1  one-cycle debouncer sample strobe, every TICK_DIV cycles
- o_cmd_valid  out  1  command offered downstream
- o_cmd_id  out  IDW  index of granted button
- i_cmd_ready  in  1  downstream accepts command
- o_pending  out  N_BTN  queued requests
- o_busy  out  1  FSM not in IDLE
- o_overflow  out  1  sticky: a rise arrived while that button was already pending

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is asynchronous and active-low. Assertion clears everything immediately, including an in-flight o_cmd_valid.
- Reset values: o_sample_en=0, o_cmd_valid=0, o_cmd_id=0, o_pending=0, o_busy=0, o_overflow=0. Tick counter, round-robin pointer, lockout counter and level_q are all 0.
- Tick counter:
  - Counts 0..TICK_DIV-1 and wraps.
  - o_sample_en is registered high for exactly the cycle after the counter equals TICK_DIV-1.
  - First strobe occurs TICK_DIV cycles after reset release.
- Edge detect:
  - level_q <= i_pb_level every cycle.
  - rise = i_pb_level & ~level_q.
- Pending bits:
  - pending[i] is set on rise[i] and cleared when i is granted (IDLE->ISSUE).
  - A rise on the grant cycle leaves the bit set; this counts as a new request.
  - A rise while pending[i] is already 1 merges into the existing request and sets o_overflow. o_overflow clears only on reset.
- FSM states: IDLE, ISSUE, LOCKOUT.
  - IDLE: if pending != 0, pick the first set bit searching upward from ptr, modulo N_BTN. Register o_cmd_id, set o_cmd_valid=1, clear that pending bit, then go to ISSUE. If pending == 0, stay in IDLE.
  - ISSUE: o_cmd_valid and o_cmd_id are held stable until i_cmd_ready. On valid&ready: o_cmd_valid<=0, ptr<=(id+1) mod N_BTN, load lockout counter with LOCKOUT_TICKS. Go to LOCKOUT, or to IDLE directly if LOCKOUT_TICKS==0.
  - LOCKOUT: decrement on each o_sample_en. Go to IDLE on the cycle the counter reaches 0. Pending bits continue to accumulate during lockout.
- Latency: an input high before edge E with level_q low gives pending[i]=1 after E, and o_cmd_valid=1 after E+1.
- i_cmd_ready is ignored when o_cmd_valid=0.
- o_busy = (state != IDLE), registered with the state.

Optional Feature:
- Macro: HOLD_REPEAT_EN.
- Defined:
  - Each button has a repeat counter that clears on a rise or while the button is low.
  - While the button is held high, the counter increments on o_sample_en.
  - On reaching REPEAT_TICKS it sets pending[i], with the same overflow rule as a rise, and restarts from 0.
- Undefined: no repeat counters exist, REPEAT_TICKS is unused, and a held button yields exactly one request.

Decomposition:
- Package pb_sched_pkg holds:
  - the FSM state enum (IDLE/ISSUE/LOCKOUT);
  - default parameter constants;
  - a function computing IDW.
- One sub-module, pb_rr_pick: combinational round-robin picker. Inputs are the request vector and ptr; outputs are a found flag and the selected index.

Test Plan:
- Reset release, idle inputs -> o_sample_en pulses for exactly 1 cycle every 10 cycles, first pulse 10 cycles after release; all other outputs stay 0.
- Button 2 rises, i_cmd_ready=1 -> o_pending=4'b0100 after 1 cycle, o_cmd_valid=1 with id=2 after 2 cycles, accepted. o_busy stays high for 8 sample ticks, then returns to IDLE.
- Buttons 0,1,3 rise together, ready held 0 for 5 cycles -> valid/id=0 stable for all 5 cycles. Then, with ready high, grants follow in order 0, 1, 3, each separated by a full lockout.
- Button 1 re-pressed while still pending -> o_overflow=1 and stays 1. Only a single command with id=1 is issued.
- Reset asserted while o_cmd_valid=1 -> o_cmd_valid, o_pending and o_busy drop to 0 immediately, without waiting for a clock edge.
- With HOLD_REPEAT_EN and REPEAT_TICKS=3, button 0 held for 10 ticks -> 1 initial request plus 3 repeat requests; without the macro, exactly 1.
